// File: rtl/div_pkg.sv
// Shared types and constants for the iterative 32-bit divider.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_unit_if.sv
// Request/response handshake bundle between EXE (master) and the divider (slave).
interface div_unit_if
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W
) ();
  logic              div_valid;
  logic              div_ready;
  logic              div_signed;
  logic [DATA_W-1:0] div_src1;
  logic [DATA_W-1:0] div_src2;
  logic              div_cancel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] div_quot;
  logic [DATA_W-1:0] div_rem;

  modport master (
    output div_valid, div_signed, div_src1, div_src2, div_cancel, out_ready,
    input  div_ready, out_valid, div_quot, div_rem
  );

  modport slave (
    input  div_valid, div_signed, div_src1, div_src2, div_cancel, out_ready,
    output div_ready, out_valid, div_quot, div_rem
  );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, subtract divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] quo_nxt
);
  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         borrow;

  // rem < divisor holds between steps, so the shifted value needs one extra bit
  // but a successful difference always fits back in W bits.
  assign shifted = {rem, quo[W-1]};
  assign borrow  = shifted < {1'b0, divisor};
  assign diff    = shifted[W-1:0] - divisor;

  always_comb begin
    rem_nxt = shifted[W-1:0];
    quo_nxt = {quo[W-2:0], 1'b0};
    if (!borrow) begin
      rem_nxt = diff;
      quo_nxt = {quo[W-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned 32-bit divider: one restoring step per cycle,
// quotient and remainder returned over a valid/ready handshake, flushable.
module div_unit
  import div_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic       clk,
  input  logic       reset,
  div_unit_if.slave  io
);
  div_state_e           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DATA_W-1:0]    rem_q, quo_q, dvsr_q;
  logic [DATA_W-1:0]    rem_nxt, quo_nxt;
  logic [DATA_W-1:0]    quot_out, rem_out;
  logic                 q_neg, r_neg;

  logic                 src1_neg, src2_neg;
  logic [DATA_W-1:0]    src1_mag, src2_mag;

  assign src1_neg = io.div_signed & io.div_src1[DATA_W-1];
  assign src2_neg = io.div_signed & io.div_src2[DATA_W-1];
  assign src1_mag = src1_neg ? -io.div_src1 : io.div_src1;
  assign src2_mag = src2_neg ? -io.div_src2 : io.div_src2;

  div_step #(.W(DATA_W)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvsr_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign io.div_ready = (state == IDLE);
  assign io.out_valid = (state == DONE);
  assign io.div_quot  = quot_out;
  assign io.div_rem   = rem_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      quot_out <= '0;
      rem_out  <= '0;
    end else if (io.div_cancel) begin
      // Flush wins over everything, including a same-cycle accept.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (io.div_valid) begin
            rem_q  <= '0;
            quo_q  <= src1_mag;
            dvsr_q <= src2_mag;
            q_neg  <= src1_neg ^ src2_neg;
            r_neg  <= src1_neg;
            cnt    <= '0;
            if (io.div_src2 == '0) begin
              quot_out <= DIV_ZERO_QUOT;
              rem_out  <= io.div_src1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == '1) begin
            quot_out <= q_neg ? -quo_nxt : quo_nxt;
            rem_out  <= r_neg ? -rem_nxt : rem_nxt;
            state    <= DONE;
          end
        end
        DONE: begin
          if (io.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: sign cases, overflow, divide by zero,
// backpressure, back-to-back, cancel and mid-operation reset.
module tb_div_unit;
  import div_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  div_unit_if #(.DATA_W(32)) bus ();

  div_unit #(.DATA_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, count edges after the accept edge until out_valid, check result.
  task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq,
                        input logic [31:0] er, input int elat);
    int n;
    int busy_bad;
    bus.div_signed = sgn;
    bus.div_src1   = a;
    bus.div_src2   = b;
    bus.div_valid  = 1'b1;
    tick();
    bus.div_valid = 1'b0;
    bus.div_src1  = ~a;
    bus.div_src2  = 32'h5;
    bus.div_signed = ~sgn;
    n = 0;
    busy_bad = 0;
    while (!bus.out_valid && n < 64) begin
      if (bus.div_ready) busy_bad++;
      tick();
      n++;
    end
    chk({tag, " latency"}, n, elat);
    chk({tag, " ready_busy"}, busy_bad, 0);
    chk({tag, " quot"}, bus.div_quot, eq);
    chk({tag, " rem"}, bus.div_rem, er);
  endtask

  task automatic finish_out(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, " hs ready"}, {31'd0, bus.div_ready}, 32'd1);
    chk({tag, " hs valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    int cnt_v;
    bus.div_valid  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_src1   = '0;
    bus.div_src2   = '0;
    bus.div_cancel = 1'b0;
    bus.out_ready  = 1'b0;
    tick();
    tick();
    chk("rst ready", {31'd0, bus.div_ready}, 32'd1);
    chk("rst valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst quot", bus.div_quot, 32'd0);
    chk("rst rem", bus.div_rem, 32'd0);
    reset = 1'b0;
    tick();

    run_op("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 32);
    finish_out("u100_7");
    run_op("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32);
    finish_out("s-7_2");
    run_op("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 32);
    finish_out("s7_-2");
    run_op("s-7_-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32);
    finish_out("s-7_-2");
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32);
    finish_out("s_ovf");
    run_op("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32);
    finish_out("u_ovf");

    // Divide by zero: DONE is registered on the accept edge itself.
    run_op("s_dz", 1'b1, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 0);
    finish_out("s_dz");
    run_op("u_dz", 1'b0, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    finish_out("u_dz");

    // Backpressure with a competing request that must be ignored.
    run_op("bp", 1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 32);
    for (int i = 0; i < 5; i++) begin
      bus.div_valid = 1'b1;
      bus.div_src1  = 32'd9;
      bus.div_src2  = 32'd3;
      tick();
      chk("bp valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp ready", {31'd0, bus.div_ready}, 32'd0);
      chk("bp quot", bus.div_quot, 32'd22);
      chk("bp rem", bus.div_rem, 32'd2);
    end
    bus.div_valid = 1'b0;
    finish_out("bp");
    run_op("b2b_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 32);
    finish_out("b2b_9_3");

    // Cancel during CALC.
    bus.div_signed = 1'b0;
    bus.div_src1   = 32'd1000;
    bus.div_src2   = 32'd3;
    bus.div_valid  = 1'b1;
    tick();
    bus.div_valid = 1'b0;
    repeat (9) tick();
    bus.div_cancel = 1'b1;
    tick();
    bus.div_cancel = 1'b0;
    chk("cancel ready", {31'd0, bus.div_ready}, 32'd1);
    chk("cancel valid", {31'd0, bus.out_valid}, 32'd0);
    cnt_v = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) cnt_v++;
      tick();
    end
    chk("cancel no result", cnt_v, 0);
    chk("cancel hold quot", bus.div_quot, 32'd3);
    chk("cancel hold rem", bus.div_rem, 32'd0);

    // Cancel together with a request: nothing is accepted.
    bus.div_src1   = 32'd100;
    bus.div_src2   = 32'd7;
    bus.div_valid  = 1'b1;
    bus.div_cancel = 1'b1;
    tick();
    bus.div_valid  = 1'b0;
    bus.div_cancel = 1'b0;
    chk("cancel+valid ready", {31'd0, bus.div_ready}, 32'd1);
    cnt_v = 0;
    for (int i = 0; i < 36; i++) begin
      if (bus.out_valid || !bus.div_ready) cnt_v++;
      tick();
    end
    chk("cancel+valid idle", cnt_v, 0);

    // Reset in the middle of CALC.
    bus.div_src1  = 32'd77;
    bus.div_src2  = 32'd7;
    bus.div_valid = 1'b1;
    tick();
    bus.div_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid rst ready", {31'd0, bus.div_ready}, 32'd1);
    chk("mid rst valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid rst quot", bus.div_quot, 32'd0);
    chk("mid rst rem", bus.div_rem, 32'd0);
    run_op("post_rst_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 32);
    finish_out("post_rst_50_5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
